// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter stage for the fetch front end. It holds the fetch PC and
// selects the next one with this priority: reset, redirect from execute,
// stall, BTB prediction, sequential increment. A small direct-mapped branch
// target buffer (BTB) predicts taken branches. A branch trained at address A
// steers fetch to its target on the edge after pc==A, so no bubble is added.
//
// Ports
//   clk            rising-edge clock
//   triggerRstN    synchronous active-low reset
//   stall          hold pc this cycle
//   redirectValid  load redirectPC (wins over stall and prediction)
//   redirectPC     resolved target from execute
//   updateValid    BTB training strobe
//   updatePC       PC of the resolved branch
//   updateTarget   resolved target of that branch
//   updateTaken    branch resolved taken
//   pc             current fetch address (registered)
//   incPC          pc + OFFSET, modulo 2^ADDR_WIDTH (combinational from pc)
//   predTaken      BTB hit for pc (combinational from pc and BTB state)
//   predTarget     BTB target for pc, zero on a miss
//   fetchValid     pc holds a fetchable address
//
// Parameter rules: OFFSET and BTB_ENTRIES are powers of two,
// BTB_ENTRIES >= 2, and ADDR_WIDTH > log2(OFFSET) + log2(BTB_ENTRIES).
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned            ADDR_WIDTH   = 12,
  parameter int unsigned            OFFSET       = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned            BTB_ENTRIES  = 8
) (
  input  logic                  clk,
  input  logic                  triggerRstN,
  input  logic                  stall,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectPC,
  input  logic                  updateValid,
  input  logic [ADDR_WIDTH-1:0] updatePC,
  input  logic [ADDR_WIDTH-1:0] updateTarget,
  input  logic                  updateTaken,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] incPC,
  output logic                  predTaken,
  output logic [ADDR_WIDTH-1:0] predTarget,
  output logic                  fetchValid
);

  localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
  localparam int unsigned OFS  = $clog2(OFFSET);
  localparam int unsigned TAGW = ADDR_WIDTH - OFS - IDXW;

  localparam logic [ADDR_WIDTH-1:0] OFFSET_W = ADDR_WIDTH'(OFFSET);

  // BTB storage: valid bits are reset, tag and target arrays are not.
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0]  btb_target [BTB_ENTRIES];

  // Lookup side: index and tag of the current pc.
  logic [IDXW-1:0] pc_idx;
  logic [TAGW-1:0] pc_tag;
  logic            pc_hit;

  assign pc_idx = pc[OFS+IDXW-1:OFS];
  assign pc_tag = pc[ADDR_WIDTH-1:OFS+IDXW];
  assign pc_hit = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag);

  assign incPC      = pc + OFFSET_W;
  assign predTaken  = pc_hit;
  assign predTarget = pc_hit ? btb_target[pc_idx] : '0;

  // Training side: index and tag of the resolved branch.
  logic [IDXW-1:0] upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_match;

  assign upd_idx   = updatePC[OFS+IDXW-1:OFS];
  assign upd_tag   = updatePC[ADDR_WIDTH-1:OFS+IDXW];
  assign upd_match = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  // Next-pc selection.
  logic [ADDR_WIDTH-1:0] next_pc;

  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no
    // latch is inferred.
    next_pc = incPC;
    if (redirectValid) begin
      next_pc = redirectPC;
    end else if (stall) begin
      next_pc = pc;
    end else if (pc_hit) begin
      next_pc = btb_target[pc_idx];
    end
  end

  // PC register and fetch-valid flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every
    // flop samples values from before the edge.
    if (!triggerRstN) begin
      pc         <= RESET_VECTOR;
      fetchValid <= 1'b0;
    end else begin
      pc         <= next_pc;
      fetchValid <= 1'b1;
    end
  end

  // Valid bits: cleared by reset, set on taken training, cleared by
  // not-taken training only when the resident entry belongs to this branch.
  always_ff @(posedge clk) begin
    if (!triggerRstN) begin
      btb_valid <= '0;
    end else if (updateValid) begin
      if (updateTaken) begin
        btb_valid[upd_idx] <= 1'b1;
      end else if (upd_match) begin
        btb_valid[upd_idx] <= 1'b0;
      end
    end
  end

  // NOTE: tag/target arrays have no reset; an entry is only observed
  // through its valid bit, so clearing the payload would only cost area.
  always_ff @(posedge clk) begin
    if (triggerRstN && updateValid && updateTaken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= updateTarget;
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter stage for the fetch front end. It holds the PC and produces the sequential next address. It takes priority redirects from execute over stalls from the hazard unit. A small direct-mapped branch target buffer (BTB) steers fetch to predicted-taken targets one cycle after the branch PC is presented.

## Interface
- ADDR_WIDTH, 12, width of every address port and of pc.
- OFFSET, 4, byte increment per instruction; power of two, ≥1.
- RESET_VECTOR, 0, pc value loaded on reset.
- BTB_ENTRIES, 8, BTB entry count; power of two, ≥2.
  - IDXW = log2(BTB_ENTRIES); OFS = log2(OFFSET).
  - Requires ADDR_WIDTH > OFS + IDXW.
- clk  in  1  clock, all state updates on rising edge.
- triggerRstN  in  1  reset, synchronous, active-low.
- stall  in  1  hold pc this cycle.
- redirectValid  in  1  load redirectPC; overrides stall and prediction.
- redirectPC  in  ADDR_WIDTH  resolved target from execute.
- updateValid  in  1  BTB training strobe.
- updatePC  in  ADDR_WIDTH  PC of the resolved branch.
- updateTarget  in  ADDR_WIDTH  resolved target of that branch.
- updateTaken  in  1  branch resolved taken.
- pc  out  ADDR_WIDTH  current fetch address (registered).
- incPC  out  ADDR_WIDTH  pc + OFFSET, combinational, modulo 2^ADDR_WIDTH.
- predTaken  out  1  BTB hit for current pc (combinational).
- predTarget  out  ADDR_WIDTH  BTB target for current pc; 0 when predTaken=0.
- fetchValid  out  1  pc holds a fetchable address.

## Operation
- BTB fields per entry: valid (1 bit), tag (ADDR_WIDTH−OFS−IDXW bits), target (ADDR_WIDTH bits).
  - index = addr[OFS+IDXW−1:OFS].
  - tag = addr[ADDR_WIDTH−1:OFS+IDXW].
- Lookup: predTaken = valid[idx(pc)] && tag[idx(pc)] == tag(pc). Outputs are driven from pc and current BTB contents only.
- Next-pc priority, highest first:
  1. reset → RESET_VECTOR
  2. redirectValid → redirectPC
  3. stall → pc (hold)
  4. predTaken → predTarget
  5. otherwise → incPC
- Training, when updateValid=1, applied on the clock edge:
  - updateTaken=1: entry[idx(updatePC)] ← {1, tag(updatePC), updateTarget}. Overwrites any alias.
  - updateTaken=0 and entry valid with matching tag: valid ← 0.
  - updateTaken=0 with no tag match: no change.
- Training is independent of stall and redirect.
- fetchValid: 0 while reset is asserted; 1 from the first edge with triggerRstN=1. Stall does not clear it.

## Timing
- Reset (triggerRstN=0 at an edge):
  - pc=RESET_VECTOR, fetchValid=0, all BTB valid bits=0.
  - Reset overrides redirect, stall and training.
  - Asserting reset mid-stream discards any in-flight redirect or update in that cycle.
- After reset: incPC=RESET_VECTOR+OFFSET, predTaken=0, predTarget=0.
- pc is updated one cycle after the controlling input is sampled. Redirect latency is 1 cycle.
- Prediction latency:
  - A trained branch at address A with pc=A yields pc=target on the next edge.
  - No bubble is inserted.
- Same-cycle update and lookup on the same index:
  - Lookup sees the pre-update contents.
  - The new entry is visible from the following cycle.
- Wrap-around: incPC = pc+OFFSET truncated to ADDR_WIDTH. No overflow flag.
- redirectValid with stall=1: pc takes redirectPC.
- Combinational paths: only pc→incPC/predTaken/predTarget. No input-to-output combinational path.

## Test plan
- Reset, then 4 free-running cycles with RESET_VECTOR=0x100 → pc 0x100,0x104,0x108,0x10C; fetchValid 0 during reset, 1 after.
- pc=0xFFC, ADDR_WIDTH=12, no inputs → incPC=0x000 and next pc=0x000; stall=1 for 3 cycles → pc held and fetchValid stays 1.
- stall=1 and redirectValid=1 with redirectPC=0x040 on the same cycle → pc=0x040 next cycle.
- Train updatePC=0x010, updateTarget=0x080, taken; later pc reaches 0x010 → predTaken=1, predTarget=0x080, next pc=0x080.
- Alias and not-taken invalidation:
  - Train 0x010→0x080, then train updatePC=0x030 (same index, BTB_ENTRIES=8) →0x0C0 → pc=0x010 misses and increments to 0x014.
  - Train not-taken at 0x030 → entry invalidated.
- Same-cycle update and lookup:
  - pc=0x020 while training 0x020→0x200 → that cycle predTaken=0 and pc→0x024.
  - Reset, then revisit 0x020 → predTaken=0 (BTB cleared).
